// File: rtl/ball_engine.sv
// ball_engine: pong ball motion, racket/wall bounces, scoring and game FSM.
// Optional BALL_SPEEDUP_EN: ball speed grows by one on every racket hit.
module ball_engine #(
  parameter int BALL_SIZE = 15,
  parameter int RACKET_H  = 80,
  parameter int X_P2_EDGE = 100,
  parameter int X_P1_EDGE = 923,
  parameter int Y_TOP     = 51,
  parameter int Y_BOT     = 717,
  parameter int WIN_SCORE = 11,
  parameter int MAX_SPEED = 4
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        end_of_frame,
  input  logic        serve,
  input  logic [9:0]  pos_of_player_1,
  input  logic [9:0]  pos_of_player_2,
  input  logic        screen_idle,
  input  logic        screen_multi,
  output logic [3:0]  points_player_1,
  output logic [3:0]  points_player_2,
  output logic [10:0] x_pos_of_ball,
  output logic [10:0] y_pos_of_ball,
  output logic        game_over,
  output logic        winner
);

  typedef logic signed [11:0] coord_t;
  typedef enum logic [2:0] {IDLE, START, FLY, SCORE, OVER} state_t;

  localparam logic [10:0] X_CTR = 11'd510;
  localparam logic [10:0] Y_CTR = 11'd377;
  localparam coord_t X_LO  = coord_t'(X_P2_EDGE);
  localparam coord_t X_HI  = coord_t'(X_P1_EDGE - BALL_SIZE);
  localparam coord_t Y_LO  = coord_t'(Y_TOP);
  localparam coord_t Y_HI  = coord_t'(Y_BOT - BALL_SIZE);
  localparam coord_t SZ    = coord_t'(BALL_SIZE);
  localparam coord_t HALF  = coord_t'(BALL_SIZE / 2);
  localparam coord_t RH    = coord_t'(RACKET_H);
  localparam coord_t ZONE1 = coord_t'(RACKET_H / 3);
  localparam coord_t ZONE2 = coord_t'(2 * RACKET_H / 3);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
`ifdef BALL_SPEEDUP_EN
  localparam logic [3:0] SPD_INC = 4'd1;
`else
  localparam logic [3:0] SPD_INC = 4'd0;
`endif

  state_t            state, state_n;
  logic [10:0]       x, y, x_n, y_n;
  logic              dx_neg, dxn_n;
  logic signed [1:0] dy, dy_n;
  logic [3:0]        spd, spd_n;
  logic [3:0]        p1, p2, p1_n, p2_n, pts;
  logic              go, win, go_n, win_n;
  logic              srv_neg, srv_n;
  logic              sc_p2, scp2_n;
  logic              award, award_n;

  coord_t            step, bx, by;
  logic signed [1:0] bdy;
  logic              bdxn, lmiss, rmiss;
  logic [3:0]        bspd, spd_up;

  function automatic logic hit_f(input coord_t b, input logic [9:0] r);
    coord_t rs;
    rs = $signed({2'b00, r});
    return (b + SZ >= rs) && (b <= rs + RH);
  endfunction

  function automatic logic signed [1:0] zone_f(input coord_t b,
                                               input logic [9:0] r);
    coord_t c;
    c = b + HALF - $signed({2'b00, r});
    if (c < ZONE1) return -2'sd1;
    if (c < ZONE2) return 2'sd0;
    return 2'sd1;
  endfunction

  assign step   = $signed({8'd0, spd});
  assign spd_up = (spd < SPD_MAX) ? spd + SPD_INC : spd;

  // Candidate motion for one frame: wall first, then racket face.
  always_comb begin
    bx    = dx_neg ? $signed({1'b0, x}) - step
                   : $signed({1'b0, x}) + step;
    by    = $signed({1'b0, y});
    bdy   = dy;
    bdxn  = dx_neg;
    bspd  = spd;
    lmiss = 1'b0;
    rmiss = 1'b0;
    if (dy == -2'sd1) by = by - step;
    else if (dy == 2'sd1) by = by + step;
    if (dy == -2'sd1 && by <= Y_LO) begin
      by  = Y_LO;
      bdy = 2'sd1;
    end else if (dy == 2'sd1 && by >= Y_HI) begin
      by  = Y_HI;
      bdy = -2'sd1;
    end
    if (dx_neg && bx <= X_LO) begin
      if (!screen_multi) begin
        bx   = X_LO;
        bdxn = 1'b0;
      end else if (hit_f(by, pos_of_player_2)) begin
        bx   = X_LO;
        bdxn = 1'b0;
        bdy  = zone_f(by, pos_of_player_2);
        bspd = spd_up;
      end else begin
        lmiss = 1'b1;
      end
    end else if (!dx_neg && bx >= X_HI) begin
      if (hit_f(by, pos_of_player_1)) begin
        bx   = X_HI;
        bdxn = 1'b1;
        bdy  = zone_f(by, pos_of_player_1);
        bspd = spd_up;
      end else begin
        rmiss = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    dxn_n   = dx_neg;
    dy_n    = dy;
    spd_n   = spd;
    p1_n    = p1;
    p2_n    = p2;
    go_n    = go;
    win_n   = win;
    srv_n   = srv_neg;
    scp2_n  = sc_p2;
    award_n = award;
    pts     = sc_p2 ? p2 : p1;
    if (screen_idle || state == IDLE) begin
      state_n = screen_idle ? IDLE : START;
      x_n     = X_CTR;
      y_n     = Y_CTR;
      dxn_n   = 1'b1;
      dy_n    = 2'sd0;
      spd_n   = 4'd1;
      p1_n    = 4'd0;
      p2_n    = 4'd0;
      go_n    = 1'b0;
      win_n   = 1'b0;
      srv_n   = 1'b1;
    end else begin
      unique case (state)
        START: begin
          x_n   = X_CTR;
          y_n   = Y_CTR;
          dy_n  = 2'sd0;
          spd_n = 4'd1;
          dxn_n = srv_neg;
          if (serve) state_n = FLY;
        end
        FLY: begin
          if (end_of_frame) begin
            x_n   = bx[11] ? 11'd0 : bx[10:0];
            y_n   = by[11] ? 11'd0 : by[10:0];
            dxn_n = bdxn;
            dy_n  = bdy;
            spd_n = bspd;
            if (lmiss) begin
              state_n = SCORE;
              scp2_n  = 1'b0;
              award_n = 1'b1;
            end else if (rmiss) begin
              state_n = SCORE;
              scp2_n  = 1'b1;
              award_n = screen_multi;
            end
          end
        end
        SCORE: begin
          if (award && pts < WIN) pts = pts + 4'd1;
          if (sc_p2) p2_n = pts;
          else p1_n = pts;
          srv_n = ~sc_p2;
          x_n   = X_CTR;
          y_n   = Y_CTR;
          if (pts == WIN) begin
            state_n = OVER;
            go_n    = 1'b1;
            win_n   = sc_p2;
          end else begin
            state_n = START;
          end
        end
        OVER: begin
          go_n = 1'b1;
          if (serve) begin
            state_n = START;
            p1_n    = 4'd0;
            p2_n    = 4'd0;
            go_n    = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state   <= IDLE;
      x       <= X_CTR;
      y       <= Y_CTR;
      dx_neg  <= 1'b1;
      dy      <= 2'sd0;
      spd     <= 4'd1;
      p1      <= 4'd0;
      p2      <= 4'd0;
      go      <= 1'b0;
      win     <= 1'b0;
      srv_neg <= 1'b1;
      sc_p2   <= 1'b0;
      award   <= 1'b0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      dx_neg  <= dxn_n;
      dy      <= dy_n;
      spd     <= spd_n;
      p1      <= p1_n;
      p2      <= p2_n;
      go      <= go_n;
      win     <= win_n;
      srv_neg <= srv_n;
      sc_p2   <= scp2_n;
      award   <= award_n;
    end
  end

  assign points_player_1 = p1;
  assign points_player_2 = p2;
  assign x_pos_of_ball   = x;
  assign y_pos_of_ball   = y;
  assign game_over       = go;
  assign winner          = win;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed scenarios plus randomized play against a
// cycle-level reference model of the pong rules.
module tb_ball_engine;

  localparam int BS    = 15;
  localparam int RH    = 80;
  localparam int XL    = 100;
  localparam int XR    = 923 - BS;
  localparam int YT    = 51;
  localparam int YB    = 717 - BS;
  localparam int WIN   = 11;
  localparam int SMAX  = 4;
`ifdef BALL_SPEEDUP_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif
  localparam int S_IDLE = 0, S_START = 1, S_FLY = 2, S_SCORE = 3, S_OVER = 4;

  logic        clk65MHz = 1'b0;
  logic        rst, end_of_frame, serve, screen_idle, screen_multi;
  logic [9:0]  pos_of_player_1, pos_of_player_2;
  logic [3:0]  points_player_1, points_player_2;
  logic [10:0] x_pos_of_ball, y_pos_of_ball;
  logic        game_over, winner;

  int n_checks = 0;
  int n_fail   = 0;

  int ms, mx, my, mdx, mdy, mspd, mp1, mp2, mgo, mwin, msrv, mscorer, maward;

  always #5 clk65MHz = ~clk65MHz;

  ball_engine dut (
    .clk65MHz        (clk65MHz),
    .rst             (rst),
    .end_of_frame    (end_of_frame),
    .serve           (serve),
    .pos_of_player_1 (pos_of_player_1),
    .pos_of_player_2 (pos_of_player_2),
    .screen_idle     (screen_idle),
    .screen_multi    (screen_multi),
    .points_player_1 (points_player_1),
    .points_player_2 (points_player_2),
    .x_pos_of_ball   (x_pos_of_ball),
    .y_pos_of_ball   (y_pos_of_ball),
    .game_over       (game_over),
    .winner          (winner)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit racket_hit(input int by, input int r);
    return (by + BS >= r) && (by <= r + RH);
  endfunction

  function automatic int racket_zone(input int by, input int r);
    int c;
    c = by + BS / 2 - r;
    if (c < RH / 3) return -1;
    if (c < 2 * RH / 3) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    ms = S_IDLE; mx = 510; my = 377; mdx = -1; mdy = 0; mspd = 1;
    mp1 = 0; mp2 = 0; mgo = 0; mwin = 0; msrv = -1;
  endtask

  task automatic model_fly();
    int nx, ny, r;
    nx = mx + mdx * mspd;
    ny = my + mdy * mspd;
    if (mdy < 0 && ny <= YT) begin ny = YT; mdy = 1; end
    else if (mdy > 0 && ny >= YB) begin ny = YB; mdy = -1; end
    if (mdx < 0 && nx <= XL) begin
      r = int'(pos_of_player_2);
      if (!screen_multi) begin
        nx = XL; mdx = 1;
      end else if (racket_hit(ny, r)) begin
        nx = XL; mdx = 1; mdy = racket_zone(ny, r);
        if (mspd < SMAX) mspd += INC;
      end else begin
        ms = S_SCORE; mscorer = 1; maward = 1;
      end
    end else if (mdx > 0 && nx >= XR) begin
      r = int'(pos_of_player_1);
      if (racket_hit(ny, r)) begin
        nx = XR; mdx = -1; mdy = racket_zone(ny, r);
        if (mspd < SMAX) mspd += INC;
      end else begin
        ms = S_SCORE; mscorer = 2; maward = int'(screen_multi);
      end
    end
    mx = nx;
    my = ny;
  endtask

  task automatic model_step();
    int pts;
    if (rst) begin
      model_reset();
    end else if (screen_idle || ms == S_IDLE) begin
      model_reset();
      ms = screen_idle ? S_IDLE : S_START;
    end else begin
      case (ms)
        S_START: begin
          mx = 510; my = 377; mdy = 0; mspd = 1; mdx = msrv;
          if (serve) ms = S_FLY;
        end
        S_FLY: if (end_of_frame) model_fly();
        S_SCORE: begin
          if (mscorer == 1) begin
            if (maward != 0 && mp1 < WIN) mp1++;
            pts = mp1; msrv = -1;
          end else begin
            if (maward != 0 && mp2 < WIN) mp2++;
            pts = mp2; msrv = 1;
          end
          mx = 510; my = 377;
          if (pts == WIN) begin
            ms = S_OVER; mgo = 1; mwin = (mscorer == 2) ? 1 : 0;
          end else begin
            ms = S_START;
          end
        end
        S_OVER: if (serve) begin
          mp1 = 0; mp2 = 0; mgo = 0; ms = S_START;
        end
        default: ms = S_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    logic [31:0] got, exp;
    @(posedge clk65MHz);
    model_step();
    #1;
    got = {x_pos_of_ball, y_pos_of_ball, points_player_1,
           points_player_2, game_over, winner};
    exp = {11'(mx), 11'(my), 4'(mp1), 4'(mp2), 1'(mgo), 1'(mwin)};
    check("outs", got, exp);
  endtask

  task automatic frame();
    end_of_frame = 1'b1;
    tick();
    end_of_frame = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic fly_until_out(input int limit);
    int n;
    n = 0;
    while (ms == S_FLY && n < limit) begin frame(); n++; end
    check("fly_bound", 32'(n < limit), 32'd1);
    repeat (2) tick();
  endtask

  task automatic fly_until_right_hit();
    int n;
    n = 0;
    while (!(mx == XR && mdx == -1) && n < 3000) begin frame(); n++; end
    check("hit_bound", 32'(n < 3000), 32'd1);
  endtask

  function automatic logic [9:0] racket_near();
    int r;
    r = my + 7 - int'($urandom_range(0, 100));
    if ($urandom_range(0, 7) == 0) r = int'($urandom_range(0, 1023));
    if (r < 0) r = 0;
    return 10'(r);
  endfunction

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rallies;
    rst = 1'b1; screen_idle = 1'b1; screen_multi = 1'b1;
    serve = 1'b0; end_of_frame = 1'b0;
    pos_of_player_1 = 10'd0; pos_of_player_2 = 10'd0;
    model_reset();
    tick();
    tick();
    check("rst_x", 32'(x_pos_of_ball), 32'd510);
    check("rst_y", 32'(y_pos_of_ball), 32'd377);
    check("rst_pts", {24'd0, points_player_1, points_player_2}, 32'd0);
    check("rst_go", {30'd0, game_over, winner}, 32'd0);

    rst = 1'b0; screen_idle = 1'b0;
    tick();
    serve = 1'b1; tick(); serve = 1'b0;
    repeat (10) frame();
    check("serve_x500", 32'(x_pos_of_ball), 32'd500);
    check("serve_y377", 32'(y_pos_of_ball), 32'd377);
    frame();
    check("still_fly", 32'(x_pos_of_ball), 32'd499);

    fly_until_out(2000);
    check("miss_p1pt", 32'(points_player_1), 32'd1);
    check("miss_p2pt", 32'(points_player_2), 32'd0);
    check("miss_ctr", {10'd0, x_pos_of_ball, y_pos_of_ball},
          {10'd0, 11'd510, 11'd377});
    serve = 1'b1; tick(); serve = 1'b0;
    frame();
    check("reserve_left", 32'(x_pos_of_ball), 32'd509);

    repeat (5) frame();
    screen_idle = 1'b1; tick();
    check("idle_ctr", {10'd0, x_pos_of_ball, y_pos_of_ball},
          {10'd0, 11'd510, 11'd377});
    check("idle_pts", 32'(points_player_1), 32'd0);
    screen_idle = 1'b0; tick();

    screen_multi = 1'b0; pos_of_player_1 = 10'd337;
    serve = 1'b1; tick(); serve = 1'b0;
    fly_until_right_hit();
    check("hit_x", 32'(x_pos_of_ball), 32'(XR));
    frame();
    check("hit_back_x", 32'(x_pos_of_ball), 32'(XR - 1 - INC));
    check("hit_dy0", 32'(y_pos_of_ball), 32'd377);

    pos_of_player_1 = 10'd310;
    fly_until_right_hit();
    n = 0;
    while (my != YB && n < 2000) begin frame(); n++; end
    check("wall_y702", 32'(y_pos_of_ball), 32'd702);
    frame();
    check("wall_bounce", 32'(y_pos_of_ball), 32'(702 - 1 - 2 * INC));

    rst = 1'b1; tick(); rst = 1'b0;
    screen_multi = 1'b1;
    pos_of_player_1 = 10'd0; pos_of_player_2 = 10'd340;
    tick();
    rallies = 0;
    while (mgo == 0 && rallies < 14) begin
      serve = 1'b1; tick(); serve = 1'b0;
      fly_until_out(2000);
      rallies++;
    end
    check("win_p2", 32'(points_player_2), 32'd11);
    check("win_p1", 32'(points_player_1), 32'd0);
    check("win_go", {30'd0, game_over, winner}, 32'd3);
    serve = 1'b1; tick(); serve = 1'b0;
    check("restart_pts", {24'd0, points_player_1, points_player_2}, 32'd0);
    check("restart_go", 32'(game_over), 32'd0);
    check("restart_x", 32'(x_pos_of_ball), 32'd510);

    for (int i = 0; i < 20000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      screen_idle = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 499) == 0) screen_multi = ~screen_multi;
      serve = ($urandom_range(0, 15) == 0);
      end_of_frame = ($urandom_range(0, 2) == 0);
      pos_of_player_1 = racket_near();
      pos_of_player_2 = racket_near();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter BALL_SIZE, default 15, ball edge length in pixels.
REQ-002 Parameter RACKET_H, default 80, racket height in pixels.
REQ-003 Parameter X_P2_EDGE, default 100, left bounce x (player 2 racket face).
REQ-004 Parameter X_P1_EDGE, default 923, right bounce x (player 1 racket face).
REQ-005 Parameter Y_TOP, default 51; parameter Y_BOT, default 717; playfield vertical limits.
REQ-006 Parameter WIN_SCORE, default 11, points ending the game (max 15).
REQ-007 Parameter MAX_SPEED, default 4, max pixels per frame per axis.
REQ-008 clk65MHz  in  1  system clock; one clock, all logic on its rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 end_of_frame  in  1  one-cycle pulse per video frame; motion update strobe.
REQ-011 serve  in  1  level; launches ball from START, restarts from OVER.
REQ-012 pos_of_player_1, pos_of_player_2  in  10 each  racket top y.
REQ-013 screen_idle  in  1  menu screen active; screen_multi  in  1  1 = two players, 0 = single.
REQ-014 points_player_1, points_player_2  out  4 each  scores.
REQ-015 x_pos_of_ball, y_pos_of_ball  out  11 each  ball top-left corner.
REQ-016 game_over  out  1  high in OVER; winner  out  1  0 = player 1, 1 = player 2, valid while game_over.

Function
REQ-017 States: IDLE, START, FLY, SCORE, OVER; all outputs registered.
REQ-018 screen_idle=1 forces IDLE next cycle from any state; overrides all other transitions.
REQ-019 IDLE: ball held at (510,377), points cleared; exits to START when screen_idle=0.
REQ-020 START: ball at (510,377); serve=1 -> FLY next cycle, x-direction = stored serve direction, dy=0, speed=1.
REQ-021 FLY: position changes only on cycles with end_of_frame=1: x += dx*speed, y += dy*speed, dx in {-1,+1}, dy in {-1,0,+1}.
REQ-022 Position arithmetic in 12-bit signed; results clamped to [Y_TOP, Y_BOT-BALL_SIZE] in y; no unsigned wrap permitted.
REQ-023 Wall bounce: y reaching Y_TOP (dy=-1) or Y_BOT-BALL_SIZE (dy=+1) -> y clamped, dy negated in same update.
REQ-024 Left check when x <= X_P2_EDGE with dx=-1; right check when x >= X_P1_EDGE-BALL_SIZE with dx=+1.
REQ-025 Hit iff y+BALL_SIZE >= racket_y and y <= racket_y+RACKET_H (inclusive); hit -> dx negated, x clamped to edge.
REQ-026 Hit zone sets dy: ball centre in upper third of racket -> -1, middle third -> 0, lower third -> +1.
REQ-027 Single mode (screen_multi=0): left edge is a wall; always bounces, pos_of_player_2 ignored, player 2 never scores.
REQ-028 Miss -> SCORE; left miss credits player 1, right miss credits player 2.
REQ-029 SCORE lasts one cycle: scorer's points +1; serve direction set toward the conceding player; next state OVER if new score == WIN_SCORE, else START.
REQ-030 OVER: ball held, game_over=1, winner valid, points frozen; serve=1 -> points cleared, START.
REQ-031 Wall bounce and racket check in the same update: both applied (dy negation then zone override on hit).
REQ-032 Points saturate at WIN_SCORE; never wrap.

Reset
REQ-033 rst=1: state IDLE, ball (510,377), points 0, dx=-1, dy=0, speed=1, game_over=0, winner=0, effective next edge.
REQ-034 rst mid-FLY or mid-SCORE discards any pending point or motion.

Configuration
REQ-035 Macro BALL_SPEEDUP_EN defined: speed +1 on each racket hit, saturating at MAX_SPEED, reset to 1 in START.
REQ-036 Macro BALL_SPEEDUP_EN undefined: speed constant 1; MAX_SPEED unused.

Verification
REQ-037 rst, screen_idle=0, serve pulse, 10 end_of_frame pulses -> ball at (500,377), state FLY.
REQ-038 Multi, pos_of_player_2=0, ball flies left -> miss at x<=100, points_player_1=1, ball (510,377) in START, next serve flies left.
REQ-039 pos_of_player_1=337, ball y=377 reaches right edge -> hit, dx=-1, dy=0; with BALL_SPEEDUP_EN speed=2.
REQ-040 dy=+1 ball reaches y=702 -> y stays 702, dy=-1 on next update.
REQ-041 points_player_2=10, player 1 misses -> points_player_2=11, game_over=1, winner=1; serve -> points 0, START.
REQ-042 screen_idle asserted mid-FLY -> IDLE next cycle, ball (510,377), points 0.
